// File: rtl/paralelo_serial_tx.sv
// Parallel-to-serial transmitter: byte FIFO feeding an MSB-first shifter,
// preceded by a fixed comma run so the downstream receiver can lock.
module paralelo_serial_tx #(
  parameter int         FIFO_DEPTH  = 4,
  parameter int         COMMA_COUNT = 4,
  parameter logic [7:0] IDLE_CHAR   = 8'hBC
) (
  input  logic                          clk_32f,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          valid_in,
  output logic                          in_ready,
  output logic                          data_out,
  output logic                          active,
  output logic                          byte_tick,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int CW  = AW + 1;
  localparam int CCW = $clog2(COMMA_COUNT + 1) + 1;

  typedef enum logic {SYNC, ACTIVE} state_t;

  state_t          state_q, state_d;
  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      cur_byte_q, cur_byte_d;
  logic [CCW-1:0]  comma_cnt_q, comma_cnt_d;
  logic            data_out_q, data_out_d;
  logic            active_q, active_d;
  logic            byte_tick_q, byte_tick_d;

  logic            push, pop, boundary, go_active;

  assign in_ready  = (count_q != CW'(FIFO_DEPTH));
  assign boundary  = (bit_cnt_q == 3'd7);
  assign push      = valid_in && in_ready;
  // The last comma boundary already behaves as ACTIVE so data can follow the final comma directly.
  assign go_active = (state_q == ACTIVE) || (comma_cnt_q >= CCW'(COMMA_COUNT));
  assign pop       = boundary && go_active && (count_q != '0);

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    count_d     = count_q;
    cur_byte_d  = cur_byte_q;
    comma_cnt_d = comma_cnt_q;
    active_d    = active_q;
    data_out_d  = cur_byte_q[3'd7 - bit_cnt_q];
    bit_cnt_d   = bit_cnt_q + 3'd1;
    byte_tick_d = boundary;

    if (boundary) begin
      if (go_active) begin
        state_d    = ACTIVE;
        active_d   = 1'b1;
        cur_byte_d = pop ? mem[rd_ptr_q] : IDLE_CHAR;
      end else begin
        cur_byte_d  = IDLE_CHAR;
        comma_cnt_d = comma_cnt_q + CCW'(1);
      end
    end

    if (push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    if (push && !pop)      count_d = count_q + CW'(1);
    else if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk_32f) begin
    if (!reset && push) mem[wr_ptr_q] <= data_in;
  end

  always_ff @(posedge clk_32f) begin
    if (reset) begin
      state_q     <= SYNC;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      bit_cnt_q   <= '0;
      cur_byte_q  <= IDLE_CHAR;
      comma_cnt_q <= CCW'(1);
      data_out_q  <= 1'b0;
      active_q    <= 1'b0;
      byte_tick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      bit_cnt_q   <= bit_cnt_d;
      cur_byte_q  <= cur_byte_d;
      comma_cnt_q <= comma_cnt_d;
      data_out_q  <= data_out_d;
      active_q    <= active_d;
      byte_tick_q <= byte_tick_d;
    end
  end

  assign data_out   = data_out_q;
  assign active     = active_q;
  assign byte_tick  = byte_tick_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_paralelo_serial_tx.sv
// Scoreboard bench: stimulus queues expected serial bytes, a negedge monitor
// reassembles data_out into bytes and checks byte_tick/active timing.
module tb_paralelo_serial_tx;

  logic       clk_32f = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       valid_in;
  logic       in_ready;
  logic       data_out;
  logic       active;
  logic       byte_tick;
  logic [2:0] fifo_count;

  int         total = 0;
  int         bad = 0;
  int         cyc = 0;
  bit         started = 1'b0;
  logic [7:0] exp_q[$];

  paralelo_serial_tx dut (
    .clk_32f   (clk_32f),
    .reset     (reset),
    .data_in   (data_in),
    .valid_in  (valid_in),
    .in_ready  (in_ready),
    .data_out  (data_out),
    .active    (active),
    .byte_tick (byte_tick),
    .fifo_count(fifo_count)
  );

  always #5 clk_32f = ~clk_32f;

  // Edge count since the last reset edge; edge 1 carries the first serial bit.
  always @(posedge clk_32f) cyc <= reset ? 0 : cyc + 1;

  task automatic chk(input string name, input int act, input int req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, req, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk_32f);
    #2;
  endtask

  task automatic goto_cyc(input int n);
    int guard;
    guard = 0;
    while (cyc != n) begin
      tick();
      guard++;
      if (guard > 1000) begin
        $display("FAIL goto_cyc timeout: got cyc %0d expected %0d", cyc, n);
        $fatal(1, "timeout");
      end
    end
  endtask

  task automatic drive(input logic v, input logic [7:0] d);
    valid_in = v;
    data_in  = d;
  endtask

  // Monitor: one serial bit per edge, one byte compare per 8 bits.
  logic [7:0] sh;
  int         nbits = 0;
  always @(negedge clk_32f) begin
    if (started) begin
      if (cyc == 0) begin
        nbits = 0;
      end else begin
        chk("byte_tick", int'(byte_tick), int'(cyc % 8 == 0));
        chk("active", int'(active), int'(cyc >= 32));
        sh = {sh[6:0], data_out};
        nbits++;
        if (nbits == 8) begin
          nbits = 0;
          if (exp_q.size() == 0) begin
            chk("unexpected_byte", int'(sh), -1);
          end else begin
            logic [7:0] e;
            e = exp_q.pop_front();
            chk("serial_byte", int'(sh), int'(e));
            $display("byte out %02h expected %02h at cyc %0d", sh, e, cyc);
          end
        end
      end
    end
  end

  initial begin
    reset = 1'b1;
    drive(1'b0, 8'h00);
    repeat (3) tick();
    chk("rst_data_out", int'(data_out), 0);
    chk("rst_active", int'(active), 0);
    chk("rst_byte_tick", int'(byte_tick), 0);
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_fifo_count", int'(fifo_count), 0);
    repeat (4) exp_q.push_back(8'hBC);
    started = 1'b1;
    reset = 1'b0;

    // Push during SYNC: held until the first data boundary at edge 32.
    goto_cyc(4);
    drive(1'b1, 8'hA5);
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'hBC);
    exp_q.push_back(8'hBC);
    tick();
    drive(1'b0, 8'h00);
    chk("sync_push_count", int'(fifo_count), 1);
    goto_cyc(31);
    chk("pre_active_count", int'(fifo_count), 1);
    tick();
    chk("pop_at_32_count", int'(fifo_count), 0);

    // Overfill: fifth byte is dropped while full.
    goto_cyc(49);
    drive(1'b1, 8'h11); tick();
    drive(1'b1, 8'h22); tick();
    drive(1'b1, 8'h33); tick();
    drive(1'b1, 8'h44); tick();
    chk("full_in_ready", int'(in_ready), 0);
    chk("full_count", int'(fifo_count), 4);
    drive(1'b1, 8'h55); tick();
    drive(1'b0, 8'h00);
    chk("drop_count", int'(fifo_count), 4);
    goto_cyc(56);
    chk("first_pop_count", int'(fifo_count), 3);
    chk("ready_after_pop", int'(in_ready), 1);
    exp_q.push_back(8'h11);
    exp_q.push_back(8'h22);
    exp_q.push_back(8'h33);
    exp_q.push_back(8'h44);
    exp_q.push_back(8'hBC);
    exp_q.push_back(8'hBC);

    // Push on a boundary into an empty FIFO: no bypass.
    goto_cyc(95);
    drive(1'b1, 8'h3C);
    tick();
    drive(1'b0, 8'h00);
    chk("boundary_push_count", int'(fifo_count), 1);
    exp_q.push_back(8'h3C);
    goto_cyc(104);
    chk("late_pop_count", int'(fifo_count), 0);

    // Simultaneous push and pop with two entries queued.
    goto_cyc(109);
    drive(1'b1, 8'h5A); tick();
    drive(1'b1, 8'h66); tick();
    drive(1'b1, 8'h77); tick();
    drive(1'b0, 8'h00);
    chk("push_pop_count", int'(fifo_count), 2);
    exp_q.push_back(8'h5A);
    exp_q.push_back(8'h66);
    exp_q.push_back(8'h77);

    // Mid-byte reset with three bytes queued.
    goto_cyc(139);
    drive(1'b1, 8'h81); tick();
    drive(1'b1, 8'h82); tick();
    drive(1'b1, 8'h83); tick();
    drive(1'b0, 8'h00);
    chk("queued3_count", int'(fifo_count), 3);
    reset = 1'b1;
    tick();
    chk("mid_rst_data_out", int'(data_out), 0);
    chk("mid_rst_count", int'(fifo_count), 0);
    chk("mid_rst_active", int'(active), 0);
    chk("mid_rst_in_ready", int'(in_ready), 1);
    chk("mid_rst_pending", exp_q.size(), 0);
    exp_q.delete();
    repeat (6) exp_q.push_back(8'hBC);
    reset = 1'b0;
    goto_cyc(48);
    chk("post_rst_count", int'(fifo_count), 0);
    goto_cyc(50);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/paralelo_serial_tx.md
Name: paralelo_serial_tx

Overview:
- Transmit-side neighbour of the serial-to-parallel receiver. Converts bytes from the upstream parallel domain into the 1-bit serial stream that the receiver samples on the falling edge of clk_32f.
- Emits a comma/idle pattern (0xBC) so the receiver can lock and reach its active state.
- Buffers incoming bytes in a small FIFO and serialises them MSB first, one bit per clk_32f.

Parameters:
- FIFO_DEPTH, 4, number of byte entries in the input FIFO (power of 2, ≥2).
- COMMA_COUNT, 4, number of 0xBC bytes sent unconditionally after reset before data is allowed.
- IDLE_CHAR, 8'hBC, byte sent for sync and whenever the FIFO is empty.

Ports:
- clk_32f, input, 1, bit clock; all logic on its rising edge.
- reset, input, 1, synchronous, active-high.
- data_in, input, 8, byte to transmit.
- valid_in, input, 1, data_in is valid this cycle.
- in_ready, output, 1, FIFO can accept a byte; asserted when not full.
- data_out, output, 1, serial bit, registered, changes only on the rising edge of clk_32f.
- active, output, 1, high once the sync phase is complete.
- byte_tick, output, 1, one-cycle pulse on the edge a new byte is loaded into the serialiser.
- fifo_count, output, $clog2(FIFO_DEPTH)+1, current FIFO occupancy.

Behaviour:
- One clock and one reset. reset is synchronous and active-high and overrides everything at the rising edge.
- Reset values: data_out=0, active=0, byte_tick=0, in_ready=1, fifo_count=0, bit_cnt=0, cur_byte=IDLE_CHAR, comma_cnt=1, state=SYNC. FIFO pointers are cleared and contents are discarded.
- Reset mid-byte aborts the byte immediately. The stream restarts with a full comma sequence.
- Serialiser, on each non-reset edge:
  - data_out <= cur_byte[7-bit_cnt].
  - bit_cnt <= bit_cnt+1, wrapping 7→0.
  - First bit appears 1 cycle after reset deasserts. Bit order is MSB first.
- Byte boundary is the edge where bit_cnt==7. On that edge cur_byte is reloaded and byte_tick=1; byte_tick=0 otherwise.
- State machine:
  - SYNC, at boundary: if comma_cnt<COMMA_COUNT, load IDLE_CHAR and comma_cnt++. Otherwise go to ACTIVE, set active=1, and apply the ACTIVE load rule on the same edge.
  - ACTIVE, at boundary: if fifo_count>0, pop the FIFO head into cur_byte. Otherwise load IDLE_CHAR.
  - ACTIVE is held until reset.
- Exactly COMMA_COUNT IDLE_CHAR bytes (8*COMMA_COUNT cycles) are sent before any data byte.
- FIFO:
  - Push when valid_in && in_ready. Pushes are accepted in any state, including SYNC.
  - in_ready = (fifo_count != FIFO_DEPTH), combinational from the count.
  - valid_in while full is ignored and the byte is dropped. Upstream must hold the byte until in_ready.
  - Pop only at a boundary in ACTIVE with fifo_count>0 evaluated before the edge. There is no bypass: a byte pushed on a boundary edge into an empty FIFO is not sent on that boundary.
  - Simultaneous push and pop leaves fifo_count unchanged. Pointers wrap modulo FIFO_DEPTH.
- Data byte equal to IDLE_CHAR is transmitted unchanged. The receiver treats it as idle, so upstream must not send it as payload.
- Minimum latency, push to first bit on data_out: push edge → next boundary (≥1 cycle) → +1 cycle.
- Throughput is 1 byte per 8 clk_32f, matching clk_4f.

Test Plan:
- Reset then idle, no valid_in: data_out is 1,0,1,1,1,1,0,0 repeated for 96 cycles. active rises on edge 32 after reset release (the 4th boundary). byte_tick pulses every 8 cycles. fifo_count=0.
- Push 0xA5 at cycle 5 (SYNC): no data before cycle 33. Bits 33–40 are 1,0,1,0,0,1,0,1, then 0xBC resumes. fifo_count is 1 from cycle 6 until the cycle-32 pop.
- After active, push 0x11, 0x22, 0x33, 0x44, 0x55 back-to-back: first 4 accepted. in_ready=0 with fifo_count=4 and the 5th is dropped until a pop. Serial output is 0x11, 0x22, 0x33, 0x44 on consecutive bytes, then 0xBC.
- Push on a boundary edge with FIFO empty: the current boundary loads 0xBC. The byte goes out on the following boundary, 8 cycles later.
- Simultaneous push and pop at a boundary with fifo_count=2: count stays 2 and order is preserved.
- Assert reset for 1 cycle mid-byte in ACTIVE with 3 bytes queued: next cycle data_out=0, fifo_count=0, active=0. Afterwards the 4-comma sequence repeats and the queued bytes are never sent.
